// File: rtl/decode_pkg.sv
// Shared opcode constants and skid-buffer state type for the decode stage.
package decode_pkg;

    localparam logic [6:0] OP_LUI         = 7'b0110111;
    localparam logic [6:0] OP_AUIPC       = 7'b0010111;
    localparam logic [6:0] OP_JAL         = 7'b1101111;
    localparam logic [6:0] OP_JALR        = 7'b1100111;
    localparam logic [6:0] OP_LOAD        = 7'b0000011;
    localparam logic [6:0] OP_STORE       = 7'b0100011;
    localparam logic [6:0] OP_BRANCH      = 7'b1100011;
    localparam logic [6:0] OP_INTEGER_IMM = 7'b0010011;
    localparam logic [6:0] OP_INTEGER     = 7'b0110011;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    function automatic logic op_supported(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
                          OP_STORE, OP_BRANCH, OP_INTEGER_IMM, OP_INTEGER};
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: picks the encoding format from the opcode
// and sign-extends from inst[31] to XLEN.
module decode_imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (inst[6:0])
            OP_LUI, OP_AUIPC:
                imm32 = {inst[31:12], 12'b0};
            OP_JAL:
                imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            OP_JALR, OP_LOAD, OP_INTEGER_IMM:
                imm32 = {{20{inst[31]}}, inst[31:20]};
            OP_BRANCH:
                imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            // Everything else is treated as a store-format immediate.
            default:
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        endcase
    end

    assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// Registered RISC-V decode stage with a two-entry (main + skid) buffer.
// Optional: define DECODE_ILLEGAL_CHECK_EN to flag unsupported encodings.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int INST_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INST_WIDTH-1:0]     inst,
    input  logic [XLEN-1:0]           in_pc,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [6:0]                op,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic [REG_ADDR_WIDTH-1:0] rs1,
    output logic [REG_ADDR_WIDTH-1:0] rs2,
    output logic [2:0]                funct3,
    output logic [6:0]                funct7,
    output logic [XLEN-1:0]           imm,
    output logic [XLEN-1:0]           out_pc,
    output logic                      illegal
);

    generate
        if (INST_WIDTH < 32) begin : g_bad_inst_width
            $error("decode_stage: INST_WIDTH must be at least 32");
        end
    endgenerate

    typedef struct packed {
        logic [6:0]                op;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [2:0]                funct3;
        logic [6:0]                funct7;
        logic [XLEN-1:0]           imm;
        logic [XLEN-1:0]           pc;
`ifdef DECODE_ILLEGAL_CHECK_EN
        logic                      illegal;
`endif
    } entry_t;

    state_t          state, state_nxt;
    entry_t          main_q, skid_q, dec;
    logic            ready_q;
    logic            acc, deq;
    logic [31:0]     inst32;
    logic [4:0]      rd5, rs15, rs25;
    logic [XLEN-1:0] dec_imm;

    assign inst32 = inst[31:0];
    assign rd5    = inst32[11:7];
    assign rs15   = inst32[19:15];
    assign rs25   = inst32[24:20];

    decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (inst32),
        .imm  (dec_imm)
    );

    always_comb begin
        dec        = '0;
        dec.op     = inst32[6:0];
        dec.rd     = rd5[REG_ADDR_WIDTH-1:0];
        dec.rs1    = rs15[REG_ADDR_WIDTH-1:0];
        dec.rs2    = rs25[REG_ADDR_WIDTH-1:0];
        dec.funct3 = inst32[14:12];
        dec.funct7 = inst32[31:25];
        dec.imm    = dec_imm;
        dec.pc     = in_pc;
`ifdef DECODE_ILLEGAL_CHECK_EN
        dec.illegal = !op_supported(inst32[6:0]) || (inst32[1:0] != 2'b11);
`endif
    end

    assign acc = in_valid && ready_q;
    assign deq = (state != ST_EMPTY) && out_ready;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (acc) state_nxt = ST_ONE;
                ST_ONE: begin
                    if (acc && !deq)      state_nxt = ST_FULL;
                    else if (deq && !acc) state_nxt = ST_EMPTY;
                end
                ST_FULL:  if (deq) state_nxt = ST_ONE;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    // in_ready comes from the next state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != ST_FULL);
            if (!flush) begin
                case (state)
                    ST_EMPTY: if (acc) main_q <= dec;
                    ST_ONE: begin
                        if (acc && deq) main_q <= dec;
                        else if (acc)   skid_q <= dec;
                    end
                    ST_FULL:  if (deq) main_q <= skid_q;
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state != ST_EMPTY);
    assign op        = main_q.op;
    assign rd        = main_q.rd;
    assign rs1       = main_q.rs1;
    assign rs2       = main_q.rs2;
    assign funct3    = main_q.funct3;
    assign funct7    = main_q.funct7;
    assign imm       = main_q.imm;
    assign out_pc    = main_q.pc;
`ifdef DECODE_ILLEGAL_CHECK_EN
    assign illegal   = main_q.illegal;
`else
    assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready, illegal;
    logic [31:0] inst, in_pc, imm, out_pc;
    logic [6:0]  op, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;

    decode_stage #(.XLEN(32), .INST_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .out_pc(out_pc),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } txn_t;
    typedef logic [96:0] flds_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    txn_t q[$];
    bit   m_rdy   = 1'b0;

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        if (v[bits-1]) return v - (32'd1 << bits);
        return v;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        case (i[6:0])
            OP_LUI, OP_AUIPC:                 return i & 32'hFFFF_F000;
            OP_JAL:    return sext({11'b0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
            OP_JALR, OP_LOAD, OP_INTEGER_IMM: return sext({20'b0, i[31:20]}, 12);
            OP_BRANCH: return sext({19'b0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
            default:   return sext({20'b0, i[31:25], i[11:7]}, 12);
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [31:0] i);
        if (!ILL_EN) return 1'b0;
        return !(i[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_STORE,
                                OP_BRANCH, OP_INTEGER_IMM, OP_INTEGER}) || (i[1:0] != 2'b11);
    endfunction

    function automatic flds_t ref_fields(input txn_t t);
        return {t.inst[6:0], t.inst[11:7], t.inst[19:15], t.inst[24:20], t.inst[14:12],
                t.inst[31:25], ref_imm(t.inst), t.pc, ref_illegal(t.inst)};
    endfunction

    // Advance one clock; the model sees exactly the inputs the DUT samples.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_rdy = 1'b0;
        end else if (flush) begin
            q.delete();
            m_rdy = 1'b1;
        end else begin
            bit acc, deq;
            acc = in_valid && m_rdy;
            deq = (q.size() > 0) && out_ready;
            if (deq) void'(q.pop_front());
            if (acc) q.push_back('{inst, in_pc});
            m_rdy = (q.size() < 2);
        end
        #1;
    endtask

    task automatic fill_full(input logic [31:0] base_pc);
        int n = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 8 && n < 2; c++) begin
            bit r;
            r = in_ready;
            in_valid = 1'b1;
            inst = 32'h00A00093 + 32'(n << 20);
            in_pc = base_pc + 32'(4 * n);
            tick();
            if (r) n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        inst = '0; in_pc = '0;
        tick(); tick();
        n_tests++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_handshake: got valid/ready %b%b expected 00", out_valid, in_ready);
        end
        n_tests++;
        if ({op, rd, rs1, rs2, funct3, funct7, imm, out_pc, illegal} !== 97'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {op, rd, rs1, rs2, funct3, funct7, imm, out_pc, illegal});
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_release: got valid/ready %b%b expected 01", out_valid, in_ready);
        end
    endtask

    task automatic test_addi();
        inst = 32'h00500093; in_pc = 32'h100; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, op, rd, rs1, imm, out_pc} !== {1'b1, 7'h13, 5'd1, 5'd0, 32'd5, 32'h100}) begin
            n_fail++;
            $display("FAIL addi: got v=%b op=%h rd=%0d rs1=%0d imm=%h pc=%h expected v=1 op=13 rd=1 rs1=0 imm=5 pc=100",
                     out_valid, op, rd, rs1, imm, out_pc);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_drain: got out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_imm();
        logic [31:0] insts [2];
        logic [31:0] exps  [2];
        insts[0] = 32'hFE000EE3; exps[0] = 32'hFFFFFFFC;
        insts[1] = 32'h12345037; exps[1] = 32'h12345000;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            inst = insts[k]; in_pc = 32'h300 + 32'(k); in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n_tests++;
            if ({out_valid, imm} !== {1'b1, exps[k]}) begin
                n_fail++;
                $display("FAIL imm_%0d: got v=%b imm=%h expected v=1 imm=%h", k, out_valid, imm, exps[k]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] b [3];
        logic [31:0] got_pc [$];
        logic [6:0]  got_op [$];
        int accepted = 0;
        bit ok;
        b[0] = 32'h00100113; b[1] = 32'h00208233; b[2] = 32'h0041A023;
        out_ready = 1'b0;
        for (int c = 0; c < 8 && accepted < 2; c++) begin
            bit r;
            r = in_ready;
            in_valid = 1'b1; inst = b[accepted]; in_pc = 32'h200 + 32'(4 * accepted);
            tick();
            if (r) accepted++;
        end
        n_tests++;
        if ({in_ready, out_valid} !== 2'b01 || accepted != 2) begin
            n_fail++;
            $display("FAIL b2b_ready_low: got ready=%b valid=%b accepts=%0d expected 0 1 2",
                     in_ready, out_valid, accepted);
        end
        inst = b[2]; in_pc = 32'h208;
        tick();
        n_tests++;
        if ({in_ready, out_valid, out_pc} !== {2'b01, 32'h200}) begin
            n_fail++;
            $display("FAIL b2b_stall_hold: got ready=%b valid=%b pc=%h expected 0 1 200",
                     in_ready, out_valid, out_pc);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bit r, v, sent;
            logic [31:0] p;
            logic [6:0]  o;
            r = in_ready; v = out_valid; p = out_pc; o = op;
            sent = (accepted < 3);
            in_valid = sent;
            inst = b[2]; in_pc = 32'h208;
            tick();
            if (v) begin got_pc.push_back(p); got_op.push_back(o); end
            if (r && sent) accepted++;
        end
        in_valid = 1'b0;
        ok = (got_pc.size() == 3);
        for (int k = 0; k < 3 && ok; k++)
            ok = (got_pc[k] == 32'h200 + 32'(4 * k)) && (got_op[k] == b[k][6:0]);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_order: got %0d outputs pcs=%p expected 3 outputs 200,204,208",
                     got_pc.size(), got_pc);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        fill_full(32'h400);
        n_tests++;
        if ({in_ready, out_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_prefill: got ready=%b valid=%b expected 0 1", in_ready, out_valid);
        end
        flush = 1'b1; in_valid = 1'b1; inst = 32'h7FF00013; in_pc = 32'h4F0;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_empty: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (out_valid) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL flush_discard: got %0d valid cycles expected 0", seen);
        end
    endtask

    task automatic test_reset_full();
        fill_full(32'h500);
        rst = 1'b1;
        tick();
        n_tests++;
        if ({out_valid, in_ready, op, rd, rs1, rs2, funct3, funct7, imm, out_pc, illegal} !== 99'd0) begin
            n_fail++;
            $display("FAIL rst_full: got valid=%b ready=%b fields=%h expected all 0", out_valid, in_ready,
                     {op, rd, rs1, rs2, funct3, funct7, imm, out_pc, illegal});
        end
        rst = 1'b0;
        tick();
        inst = 32'hFFF00113; in_pc = 32'h600; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, op, rd, rs1, imm, out_pc} !== {1'b1, 7'h13, 5'd2, 5'd0, 32'hFFFFFFFF, 32'h600}) begin
            n_fail++;
            $display("FAIL rst_recover: got v=%b op=%h rd=%0d rs1=%0d imm=%h pc=%h expected v=1 op=13 rd=2 rs1=0 imm=ffffffff pc=600",
                     out_valid, op, rd, rs1, imm, out_pc);
        end
        tick();
    endtask

    task automatic test_illegal();
        inst = 32'h0000007F; in_pc = 32'h700; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, illegal} !== {1'b1, ILL_EN}) begin
            n_fail++;
            $display("FAIL illegal: got v=%b illegal=%b expected v=1 illegal=%b", out_valid, illegal, ILL_EN);
        end
        tick();
    endtask

    task automatic test_random();
        logic [6:0] ops [9];
        ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_STORE,
                OP_BRANCH, OP_INTEGER_IMM, OP_INTEGER};
        for (int c = 0; c < 500; c++) begin
            logic [31:0] r32;
            r32 = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            inst      = ($urandom_range(0, 7) == 0) ? r32 : {r32[31:7], ops[$urandom_range(0, 8)]};
            in_pc     = $urandom;
            tick();
            n_tests++;
            if ({out_valid, in_ready} !== {q.size() > 0, m_rdy}) begin
                n_fail++;
                $display("FAIL rand_handshake cyc %0d: got valid=%b ready=%b expected %b %b",
                         c, out_valid, in_ready, q.size() > 0, m_rdy);
            end
            if (q.size() > 0) begin
                n_tests++;
                if ({op, rd, rs1, rs2, funct3, funct7, imm, out_pc, illegal} !== ref_fields(q[0])) begin
                    n_fail++;
                    $display("FAIL rand_fields cyc %0d: got %h expected %h", c,
                             {op, rd, rs1, rs2, funct3, funct7, imm, out_pc, illegal}, ref_fields(q[0]));
                end
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_imm();
        test_back_to_back();
        test_flush();
        test_reset_full();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of imm and pc.
REQ-002 SHALL have parameter INST_WIDTH, default 32, instruction width; values below 32 SHALL be a parameter error.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 5, register index width; rd/rs1/rs2 SHALL be the low REG_ADDR_WIDTH bits of the 5-bit encoding fields.
REQ-004 SHALL have ports: clk input 1 clock (one clock, all logic on its rising edge); rst input 1 synchronous active-high reset.
REQ-005 SHALL have ports: in_valid input 1; in_ready output 1; inst input INST_WIDTH; in_pc input XLEN; flush input 1, discards all held entries.
REQ-006 SHALL have ports: out_valid output 1; out_ready input 1; op output 7; rd, rs1, rs2 output REG_ADDR_WIDTH each; funct3 output 3; funct7 output 7; imm output XLEN; out_pc output XLEN; illegal output 1.

Function
REQ-007 SHALL decode fields as op=inst[6:0], rd=inst[11:7], funct3=inst[14:12], rs1=inst[19:15], rs2=inst[24:20], funct7=inst[31:25].
REQ-008 SHALL select imm by opcode: LUI/AUIPC U-type; JAL J-type; JALR/LOAD/OP-IMM I-type; BRANCH B-type; all other opcodes S-type; sign-extended from inst[31] to XLEN (U-type: inst[31:12] followed by 12 zeros, then sign-extended when XLEN>32).
REQ-009 SHALL transfer input when in_valid&&in_ready, and output when out_valid&&out_ready, both sampled at the rising edge.
REQ-010 SHALL register decoded results: an instruction accepted in cycle N SHALL appear on the outputs at cycle N+1 with empty storage (latency 1).
REQ-011 SHALL hold 2 entries (main + skid) using a state machine: EMPTY, ONE, FULL.
REQ-012 SHALL transition EMPTY->ONE on accept; ONE->EMPTY on output without accept; ONE->FULL on accept without output; FULL->ONE on output; ONE and FULL SHALL hold otherwise.
REQ-013 SHALL drive in_ready = (state != FULL) as a registered signal, with no combinational path from out_ready.
REQ-014 SHALL drive out_valid = (state != EMPTY); output fields SHALL stay stable while out_valid && !out_ready.
REQ-015 SHALL keep order: the skid entry moves to main on the output transfer, and the simultaneous accept lands in skid, so FIFO order holds.
REQ-016 SHALL, on flush, go to EMPTY next cycle and ignore any same-cycle accept; flush SHALL take priority over all transfers.
REQ-017 SHALL pass in_pc to out_pc unchanged, aligned with its instruction.

Reset
REQ-018 SHALL on rst go to EMPTY, with out_valid=0, in_ready=0 during reset and 1 from the first cycle after rst deasserts; op, rd, rs1, rs2, funct3, funct7, imm, out_pc = 0; illegal=0.
REQ-019 SHALL let rst mid-transfer drop held entries with no output handshake, and SHALL give rst priority over flush.

Configuration
REQ-020 SHALL, with DECODE_ILLEGAL_CHECK_EN defined, set illegal=1 for any op outside the nine supported opcodes or inst[1:0]!=2'b11, registered with its entry.
REQ-021 SHALL, without DECODE_ILLEGAL_CHECK_EN, tie illegal to constant 0 and add no checking logic.

Structure
REQ-022 SHALL place opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_STORE, OP_BRANCH, OP_INTEGER_IMM, OP_INTEGER) and an enum for the state type in shared package decode_pkg.
REQ-023 SHALL implement imm selection in combinational sub-module decode_imm_gen (parameter XLEN; inputs inst; output imm), instantiated once on the input path.

Verification
REQ-024 SHALL test: inst=32'h00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, op=7'h13, rd=1, rs1=0, imm=5.
REQ-025 SHALL test: inst=32'hFE000EE3 (branch imm -4) -> imm=32'hFFFFFFFC; inst=32'h12345037 (LUI) -> imm=32'h12345000.
REQ-026 SHALL test: out_ready=0, present 3 back-to-back instructions -> in_ready falls after 2 accepts; raising out_ready yields all 3 in order with no loss or duplication.
REQ-027 SHALL test: FULL state, flush=1 while in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input not emitted.
REQ-028 SHALL test: rst asserted while FULL -> next cycle out_valid=0, all outputs 0; after release, first accepted instruction decodes correctly.
REQ-029 SHALL test: with DECODE_ILLEGAL_CHECK_EN, inst=32'h0000007F -> illegal=1; without it, illegal=0 for the same stimulus.
